// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter, one digit per clock, MSD first
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - conversion request, sampled only while idle
//   bcd_in - packed BCD digits, units digit at [3:0]
//   busy   - conversion in progress
//   done   - one-cycle pulse when bin/err are updated
//   bin    - binary result, held until the next done
//   err    - last result contained a digit above 9 (bin forced to 0)
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int ACC_W = BIN_W + 4;

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] shadow;
    logic [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]    idx;
    logic                bad;
    logic [3:0]          dig;
    logic [ACC_W-1:0]    acc10;
    logic                any_bad;

    // acc*10 + digit built from shifts so no multiplier is inferred
    always_comb begin
        dig   = 4'(shadow >> {idx, 2'b00});
        acc10 = (acc << 3) + (acc << 1) + {{BIN_W{1'b0}}, dig};
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            any_bad = any_bad | (bcd_in[i*4 +: 4] > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= '0;
            acc    <= '0;
            idx    <= '0;
            bad    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bin    <= '0;
            err    <= 1'b0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                shadow <= bcd_in;
                acc    <= '0;
                idx    <= IDX_W'(DIGITS - 1);
                bad    <= any_bad;
                busy   <= 1'b1;
                state  <= CONV;
            end
        end else begin
            acc <= acc10;
            idx <= idx - IDX_W'(1);
            if (idx == '0) begin
                bin   <= bad ? '0 : acc10[BIN_W-1:0];
                err   <= bad;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin;
    logic        err;
    int          total = 0;
    int          bad = 0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin(bin), .err(err)
    );

    always #5 clk = ~clk;

    // Pulses start for one edge, then runs until done (bounded). Leaves caller in the done cycle.
    task automatic convert(input logic [11:0] v, output int busy_n, output int wait_n,
                           output logic [9:0] b, output logic e, output logic overlap);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_n  = 0;
        wait_n  = 0;
        overlap = 1'b0;
        while (!done && wait_n < 20) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            wait_n++;
        end
        if (busy && done) overlap = 1'b1;
        b = bin;
        e = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (bin !== 10'd0) begin bad++; $display("FAIL reset_bin got=%0d exp=0", bin); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        int bn, wn; logic [9:0] b; logic e, ov;
        convert(12'h999, bn, wn, b, e, ov);
        total++; if (bn != 3) begin bad++; $display("FAIL max_busy_cycles got=%0d exp=3", bn); end
        total++; if (wn != 3) begin bad++; $display("FAIL max_latency got=%0d exp=3", wn); end
        total++; if (b !== 10'd999) begin bad++; $display("FAIL max_bin got=%0d exp=999", b); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL max_err got=%b exp=0", e); end
        total++; if (ov) begin bad++; $display("FAIL max_busy_done_overlap got=1 exp=0"); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_width got=%b exp=0", done); end
        total++; if (bin !== 10'd999) begin bad++; $display("FAIL max_bin_hold got=%0d exp=999", bin); end
    endtask

    task automatic test_values();
        logic [11:0] vin [5] = '{12'h000, 12'h512, 12'h100, 12'h090, 12'h037};
        logic [9:0]  vex [5] = '{10'd0, 10'd512, 10'd100, 10'd90, 10'd37};
        int bn, wn; logic [9:0] b; logic e, ov;
        for (int i = 0; i < 5; i++) begin
            convert(vin[i], bn, wn, b, e, ov);
            total++; if (b !== vex[i] || e !== 1'b0 || wn != 3)
                begin bad++; $display("FAIL value_%h got bin=%0d err=%b lat=%0d exp bin=%0d err=0 lat=3", vin[i], b, e, wn, vex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_invalid();
        int bn, wn; logic [9:0] b; logic e, ov;
        convert(12'h1A3, bn, wn, b, e, ov);
        total++; if (wn != 3) begin bad++; $display("FAIL inv_latency got=%0d exp=3", wn); end
        total++; if (b !== 10'd0 || e !== 1'b1) begin bad++; $display("FAIL inv_1A3 got bin=%0d err=%b exp bin=0 err=1", b, e); end
        @(posedge clk); #1;
        convert(12'h007, bn, wn, b, e, ov);
        total++; if (b !== 10'd7 || e !== 1'b0) begin bad++; $display("FAIL after_inv got bin=%0d err=%b exp bin=7 err=0", b, e); end
        @(posedge clk); #1;
        convert(12'hF00, bn, wn, b, e, ov);
        total++; if (b !== 10'd0 || e !== 1'b1) begin bad++; $display("FAIL inv_F00 got bin=%0d err=%b exp bin=0 err=1", b, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int n = 0; logic [9:0] b = '0;
        bcd_in = 12'h123; start = 1'b1;
        @(posedge clk); #1;
        bcd_in = 12'h456;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin n++; b = bin; end
            @(posedge clk); #1;
        end
        total++; if (n != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", n); end
        total++; if (b !== 10'd123) begin bad++; $display("FAIL ignore_bin got=%0d exp=123", b); end
    endtask

    task automatic test_back_to_back();
        int n = 0; int k1 = 0; int k2 = 0; logic [9:0] b1 = '0; logic [9:0] b2 = '0;
        bcd_in = 12'h123; start = 1'b1;
        @(posedge clk); #1;
        bcd_in = 12'h456;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n++;
                if (n == 1) begin k1 = k; b1 = bin; end
                else if (n == 2) begin k2 = k; b2 = bin; start = 1'b0; end
            end
        end
        start = 1'b0;
        total++; if (k1 != 3 || b1 !== 10'd123) begin bad++; $display("FAIL b2b_first got edge=%0d bin=%0d exp edge=3 bin=123", k1, b1); end
        total++; if (k2 != 7 || b2 !== 10'd456) begin bad++; $display("FAIL b2b_second got edge=%0d bin=%0d exp edge=7 bin=456", k2, b2); end
        total++; if (n != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n = 0; int bn, wn; logic [9:0] b; logic e, ov;
        bcd_in = 12'h321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || bin !== 10'd0 || err !== 1'b0)
            begin bad++; $display("FAIL rst_mid got busy=%b bin=%0d err=%b exp 0/0/0", busy, bin, err); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", n); end
        convert(12'h321, bn, wn, b, e, ov);
        total++; if (b !== 10'd321 || e !== 1'b0 || wn != 3) begin bad++; $display("FAIL rst_mid_next got bin=%0d err=%b lat=%0d exp 321/0/3", b, e, wn); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_max();
        test_values();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
